fetch_prefetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the 32-bit MIPS pipeline. Owns the PC and issues

---
 rtl/fetch_prefetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_prefetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC owner, in-order imem request issue, prefetch queue and redirect squash
module fetch_prefetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4,
    output logic              rsp_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  filled;
    logic [PW-1:0]     head, tail, fill_ptr;
    logic [CW-1:0]     alloc, pend, drop, inflight;
    logic [CW:0]       occ;
    logic              accept, pop, fill, stray;

    // Handshakes and response classification; a response with drop>0 is always squashed
    always_comb begin
        occ = {1'b0, alloc} + {1'b0, drop};
        inflight = drop + pend;
        imem_req_valid = reset & (occ < FULL) & ~redirect_valid;
        imem_req_addr = fetch_pc;
        if_valid = reset & filled[head] & ~redirect_valid;
        if_pc = reset ? pc_q[head] : '0;
        if_inst = reset ? inst_q[head] : '0;
        if_pc4 = reset ? pc_q[head] + ADDR_W'(4) : '0;
        accept = imem_req_valid & imem_req_ready;
        pop = if_valid & if_ready;
        fill = imem_rsp_valid & (drop == '0) & (pend != '0) & ~redirect_valid;
        stray = imem_rsp_valid & (drop == '0) & (pend == '0);
    end

    // Control state: redirect clears the queue and converts outstanding requests into drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            head <= '0;
            tail <= '0;
            fill_ptr <= '0;
            alloc <= '0;
            pend <= '0;
            drop <= '0;
            filled <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (stray)
                rsp_err <= 1'b1;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                head <= '0;
                tail <= '0;
                fill_ptr <= '0;
                alloc <= '0;
                pend <= '0;
                filled <= '0;
                drop <= inflight - CW'(imem_rsp_valid && inflight != '0);
            end else begin
                if (accept) begin
                    filled[tail] <= 1'b0;
                    tail <= tail + PW'(1);
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (imem_rsp_valid && drop != '0)
                    drop <= drop - CW'(1);
                if (fill) begin
                    filled[fill_ptr] <= 1'b1;
                    fill_ptr <= fill_ptr + PW'(1);
                end
                if (pop) begin
                    filled[head] <= 1'b0;
                    head <= head + PW'(1);
                end
                alloc <= alloc + CW'(accept) - CW'(pop);
                pend <= pend + CW'(accept) - CW'(fill);
            end
        end
    end

    // Entry payload storage; validity is tracked by the filled bits, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept)
            pc_q[tail] <= fetch_pc;
        if (fill)
            inst_q[fill_ptr] <= imem_rsp_data;
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed per-cycle vectors plus hand sequences for redirect, wrap, error and reset
module tb_fetch_prefetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        rsp_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        ird;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[$];

    fetch_prefetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_inst(if_inst),
        .if_pc(if_pc),
        .if_pc4(if_pc4),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] rp, input logic rq, input logic rv,
                         input logic [31:0] rdat, input logic ir);
        redirect_valid = rd;
        redirect_pc = rp;
        imem_req_ready = rq;
        imem_rsp_valid = rv;
        imem_rsp_data = rdat;
        if_ready = ir;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        // steady fetch, then zero-wait sustained stream
        tbl.push_back('{0, 0, 1, 0, 32'h0,         1, 1, 32'h00, 0, 32'h0,  32'h0});
        tbl.push_back('{0, 0, 1, 1, 32'hAB000000, 1, 1, 32'h04, 0, 32'h0,  32'h0});
        tbl.push_back('{0, 0, 1, 1, 32'hAB000004, 1, 1, 32'h08, 1, 32'h00, 32'hAB000000});
        tbl.push_back('{0, 0, 1, 1, 32'hAB000008, 1, 1, 32'h0C, 1, 32'h04, 32'hAB000004});
        tbl.push_back('{0, 0, 0, 1, 32'hAB00000C, 1, 1, 32'h10, 1, 32'h08, 32'hAB000008});
        tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 1, 32'h10, 1, 32'h0C, 32'hAB00000C});
        tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 1, 32'h10, 0, 32'h0,  32'h0});
        // decode stalled: exactly DEPTH requests, then issue blocked until a pop
        tbl.push_back('{0, 0, 1, 0, 32'h0,         0, 1, 32'h10, 0, 32'h0,  32'h0});
        tbl.push_back('{0, 0, 1, 1, 32'hAB000010, 0, 1, 32'h14, 0, 32'h0,  32'h0});
        tbl.push_back('{0, 0, 1, 1, 32'hAB000014, 0, 1, 32'h18, 1, 32'h10, 32'hAB000010});
        tbl.push_back('{0, 0, 1, 1, 32'hAB000018, 0, 1, 32'h1C, 1, 32'h10, 32'hAB000010});
        tbl.push_back('{0, 0, 1, 1, 32'hAB00001C, 0, 0, 32'h20, 1, 32'h10, 32'hAB000010});
        tbl.push_back('{0, 0, 1, 0, 32'h0,         0, 0, 32'h20, 1, 32'h10, 32'hAB000010});
        tbl.push_back('{0, 0, 1, 0, 32'h0,         1, 0, 32'h20, 1, 32'h10, 32'hAB000010});
        tbl.push_back('{0, 0, 1, 0, 32'h0,         0, 1, 32'h20, 1, 32'h14, 32'hAB000014});
        tbl.push_back('{0, 0, 1, 1, 32'hAB000020, 1, 0, 32'h24, 1, 32'h14, 32'hAB000014});
        tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 1, 32'h24, 1, 32'h18, 32'hAB000018});
        tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 1, 32'h24, 1, 32'h1C, 32'hAB00001C});
        tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 1, 32'h24, 1, 32'h20, 32'hAB000020});
        tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 1, 32'h24, 0, 32'h0,  32'h0});
        // two in flight, redirect to 0x100, both stale responses squashed
        tbl.push_back('{0, 0, 1, 0, 32'h0,         1, 1, 32'h24, 0, 32'h0,  32'h0});
        tbl.push_back('{0, 0, 1, 0, 32'h0,         1, 1, 32'h28, 0, 32'h0,  32'h0});
        tbl.push_back('{1, 32'h100, 1, 0, 32'h0,   1, 0, 32'h2C, 0, 32'h0,  32'h0});
        tbl.push_back('{0, 0, 1, 1, 32'hDEAD0024, 1, 1, 32'h100, 0, 32'h0, 32'h0});
        tbl.push_back('{0, 0, 0, 1, 32'hDEAD0028, 1, 1, 32'h104, 0, 32'h0, 32'h0});
        tbl.push_back('{0, 0, 0, 1, 32'hAB000100, 1, 1, 32'h104, 0, 32'h0, 32'h0});
        tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 1, 32'h104, 1, 32'h100, 32'hAB000100});
        tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 1, 32'h104, 0, 32'h0, 32'h0});

        #1;
        chk("rst req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst req_addr", imem_req_addr, 32'h0);
        chk("rst if_valid", 32'(if_valid), 32'h0);
        chk("rst if_pc4", if_pc4, 32'h0);
        chk("rst rsp_err", 32'(rsp_err), 32'h0);
        tick();
        tick();
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].ird);
            #1;
            chk($sformatf("c%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_req));
            chk($sformatf("c%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("c%0d if_valid", i), 32'(if_valid), 32'(tbl[i].e_ifv));
            if (tbl[i].e_ifv) begin
                chk($sformatf("c%0d if_pc", i), if_pc, tbl[i].e_pc);
                chk($sformatf("c%0d if_inst", i), if_inst, tbl[i].e_inst);
                chk($sformatf("c%0d if_pc4", i), if_pc4, tbl[i].e_pc + 32'd4);
            end
            chk($sformatf("c%0d rsp_err", i), 32'(rsp_err), 32'h0);
            tick();
        end

        // redirect coinciding with a response and a pop: two in flight before, one drop after
        drive(0, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 32'hAB000104, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        #1;
        chk("r4 pre if_valid", 32'(if_valid), 32'h1);
        chk("r4 pre if_pc", if_pc, 32'h104);
        tick();
        drive(1, 32'h200, 1, 1, 32'hDEAD0108, 1);
        #1;
        chk("r4 if_valid", 32'(if_valid), 32'h0);
        chk("r4 req_valid", 32'(imem_req_valid), 32'h0);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        #1;
        chk("r4 restart addr", imem_req_addr, 32'h200);
        chk("r4 if_valid after", 32'(if_valid), 32'h0);
        tick();
        tick();
        #1;
        chk("r4 third addr", imem_req_addr, 32'h208);
        chk("r4 third valid", 32'(imem_req_valid), 32'h1);
        tick();
        #1;
        chk("r4 full with drop", 32'(imem_req_valid), 32'h0);
        tick();
        drive(0, 0, 0, 1, 32'hDEAD010C, 1);
        tick();
        drive(0, 0, 0, 1, 32'hAB000200, 1);
        #1;
        chk("r4 drop done", 32'(imem_req_valid), 32'h1);
        chk("r4 stale hidden", 32'(if_valid), 32'h0);
        tick();
        drive(0, 0, 0, 1, 32'hAB000204, 1);
        #1;
        chk("r4 head pc", if_pc, 32'h200);
        chk("r4 head inst", if_inst, 32'hAB000200);
        tick();
        drive(0, 0, 0, 1, 32'hAB000208, 1);
        #1;
        chk("r4 pc 204", if_pc, 32'h204);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("r4 inst 208", if_inst, 32'hAB000208);
        chk("r4 no err", 32'(rsp_err), 32'h0);
        tick();

        // address wrap at the top of the 32-bit space
        drive(1, 32'hFFFFFFFC, 0, 0, 0, 1);
        tick();
        drive(0, 0, 1, 0, 0, 1);
        #1;
        chk("wrap addr top", imem_req_addr, 32'hFFFFFFFC);
        tick();
        drive(0, 0, 1, 1, 32'hAB0000FC, 1);
        #1;
        chk("wrap addr zero", imem_req_addr, 32'h0);
        tick();
        drive(0, 0, 0, 1, 32'hAB000000, 0);
        #1;
        chk("wrap if_pc", if_pc, 32'hFFFFFFFC);
        chk("wrap if_pc4", if_pc4, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        #1;
        chk("wrap next pc", if_pc, 32'h0);
        chk("wrap next pc4", if_pc4, 32'h4);
        tick();

        // stray response with nothing in flight
        drive(0, 0, 0, 1, 32'hDEADBEEF, 1);
        #1;
        chk("err before", 32'(rsp_err), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("err set", 32'(rsp_err), 32'h1);
        chk("err queue empty", 32'(if_valid), 32'h0);
        chk("err fetch pc", imem_req_addr, 32'h4);
        tick();
        #1;
        chk("err sticky", 32'(rsp_err), 32'h1);

        // asynchronous reset in the middle of a stream
        drive(0, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 32'hAB000004, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("ar pre if_valid", 32'(if_valid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar req_valid", 32'(imem_req_valid), 32'h0);
        chk("ar req_addr", imem_req_addr, 32'h0);
        chk("ar if_valid", 32'(if_valid), 32'h0);
        chk("ar if_pc", if_pc, 32'h0);
        chk("ar if_inst", if_inst, 32'h0);
        chk("ar if_pc4", if_pc4, 32'h0);
        chk("ar rsp_err", 32'(rsp_err), 32'h0);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("ar restart valid", 32'(imem_req_valid), 32'h1);
        chk("ar restart addr", imem_req_addr, 32'h0);
        chk("ar restart if_valid", 32'(if_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
